// File: rtl/tinyalu_pkg.sv
// Shared types and limits for the TinyALU responder and its benches.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } op_type;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int MUL_LATENCY_MIN = 2;
    localparam int MUL_LATENCY_MAX = 8;

    // True for opcodes that launch an operation; no_op, rst_op and the
    // unused encodings 5/6 do not.
    function automatic logic is_exec_op(input logic [2:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            3'(add_op), 3'(and_op), 3'(xor_op), 3'(mul_op): hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Registered 8x8 multiplier whose valid flag trails the product register
// through a (LATENCY-1)-deep shift register. clr drops any op in flight.
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] product
);

    localparam int DEPTH = LATENCY - 1;

    logic [15:0]      prod_q, prod_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    // Product capture and valid shift, both killed by clr.
    always_comb begin
        prod_d = prod_q;
        vld_d  = '0;
        if (in_valid && !clr) begin
            prod_d = 16'(a) * 16'(b);
        end
        vld_d[0] = in_valid && !clr;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1] && !clr;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            vld_q  <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign product   = prod_q;

endmodule

// File: rtl/tinyalu_responder.sv
// TinyALU start/done responder: one-cycle add/and/xor, multi-cycle mul.
//
// state | meaning
// IDLE  | waiting for start with an executable opcode
// EXEC  | operands captured, counting down to completion
// DONE  | done pulse cycle, result just registered
// HOLD  | initiator still holding start, wait for it to drop
module tinyalu_responder
    import tinyalu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    op_type      op_q, op_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        mul_start, mul_clr, mul_valid;
    logic [15:0] mul_product;
    logic [15:0] exec_result;

    tinyalu_mul_pipe #(.LATENCY(MUL_LATENCY)) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .clr       (mul_clr),
        .in_valid  (mul_start),
        .a         (a_q),
        .b         (b_q),
        .out_valid (mul_valid),
        .product   (mul_product)
    );

    // Result of the captured operation, zero-extended to 16 bits.
    always_comb begin
        exec_result = '0;
        case (op_q)
            add_op:  exec_result = 16'(a_q) + 16'(b_q);
            and_op:  exec_result = {8'h00, a_q & b_q};
            xor_op:  exec_result = {8'h00, a_q ^ b_q};
            mul_op:  exec_result = mul_product;
            default: exec_result = '0;
        endcase
    end

    // Next-state, capture and output logic. The mul pipe is launched on the
    // first EXEC cycle (counter still at its load value) so its valid output
    // lines up with the counter reaching zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        mul_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_exec_op(op)) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op_type'(op);
                        cnt_d   = (op == 3'(mul_op)) ? 4'(MUL_LATENCY - 1) : 4'd0;
                        state_d = ST_EXEC;
                    end else if (op == 3'(rst_op)) begin
                        result_d = '0;
                    end
                end
            end
            ST_EXEC: begin
                mul_start = (op_q == mul_op) && (cnt_q == 4'(MUL_LATENCY - 1));
                if (!start) begin
                    mul_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    if ((op_q == mul_op) ? mul_valid : (cnt_q == 4'd0)) begin
                        result_d = exec_result;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = start ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= no_op;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_tinyalu_responder.sv
// Self-checking bench for tinyalu_responder: directed protocol cases plus
// randomized operations against a plain-arithmetic reference model.
module tb_tinyalu_responder;
    import tinyalu_pkg::*;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_result = '0;

    tinyalu_responder #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_result(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int r;
        r = 0;
        case (o)
            3'(add_op): r = int'(a) + int'(b);
            3'(and_op): r = int'(a & b);
            3'(xor_op): r = int'(a ^ b);
            3'(mul_op): r = int'(a) * int'(b);
            default:    r = 0;
        endcase
        return 16'(r);
    endfunction

    function automatic int model_latency(input logic [2:0] o);
        return (o == 3'(mul_op)) ? MUL_LAT : 1;
    endfunction

    // One initiator transaction, entered and left at a negedge.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input bit scramble, input int hold_cycles);
        int lat;
        lat   = -1;
        A     = a;
        B     = b;
        op    = o;
        start = 1'b1;
        @(negedge clk);
        check_val("busy_after_accept", 32'(busy), 32'd1);
        check_val("done_at_accept", 32'(done), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            if (scramble) begin
                A  = 8'($urandom);
                B  = 8'($urandom);
                op = 3'($urandom);
            end
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            check_val("result_held_exec", 32'(result), 32'(exp_result));
        end
        check_val("latency", 32'(lat), 32'(model_latency(o)));
        exp_result = model_result(o, a, b);
        check_val("result", 32'(result), 32'(exp_result));
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            check_val("hold_done", 32'(done), 32'd0);
            check_val("hold_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_result", 32'(result), 32'(exp_result));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal_ops [4];
        logic [2:0] quiet_ops [3];
        legal_ops = '{3'(add_op), 3'(and_op), 3'(xor_op), 3'(mul_op)};
        quiet_ops = '{3'(no_op), 3'd5, 3'd6};

        #2;
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_result", 32'(result), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'(add_op), 8'hFF, 8'h01, 1'b0, 0);
        check_val("add_ff_01", 32'(result), 32'h0100);
        run_op(3'(and_op), 8'hF0, 8'h3C, 1'b0, 0);
        check_val("and_f0_3c", 32'(result), 32'h0030);
        run_op(3'(xor_op), 8'hAA, 8'hFF, 1'b0, 0);
        check_val("xor_aa_ff", 32'(result), 32'h0055);
        run_op(3'(mul_op), 8'hFF, 8'hFF, 1'b1, 0);
        check_val("mul_ff_ff", 32'(result), 32'hFE01);

        run_op(3'(add_op), 8'h2F, 8'h11, 1'b0, 5);

        run_op(3'(mul_op), 8'h14, 8'hE9, 1'b0, 0);
        check_val("mul_1234", 32'(result), 32'h1234);

        foreach (quiet_ops[i]) begin
            A     = 8'($urandom);
            B     = 8'($urandom);
            op    = quiet_ops[i];
            start = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check_val("quiet_done", 32'(done), 32'd0);
                check_val("quiet_busy", 32'(busy), 32'd0);
                check_val("quiet_result", 32'(result), 32'(exp_result));
            end
            start = 1'b0;
            @(negedge clk);
        end

        A     = 8'($urandom);
        B     = 8'($urandom);
        op    = 3'(rst_op);
        start = 1'b1;
        @(negedge clk);
        exp_result = '0;
        check_val("rstop_result", 32'(result), 32'd0);
        check_val("rstop_done", 32'(done), 32'd0);
        check_val("rstop_busy", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        check_val("rstop_done_after", 32'(done), 32'd0);

        run_op(3'(xor_op), 8'h5A, 8'h0F, 1'b0, 0);
        A     = 8'hFF;
        B     = 8'hFF;
        op    = 3'(mul_op);
        start = 1'b1;
        @(negedge clk);
        check_val("abort_busy", 32'(busy), 32'd1);
        start = 1'b0;
        for (int c = 0; c < MUL_LAT + 2; c++) begin
            @(negedge clk);
            check_val("abort_done", 32'(done), 32'd0);
            check_val("abort_result", 32'(result), 32'(exp_result));
            check_val("abort_busy_low", 32'(busy), 32'd0);
        end
        run_op(3'(add_op), 8'd2, 8'd3, 1'b0, 0);
        check_val("add_2_3", 32'(result), 32'h0005);

        repeat (40) begin
            run_op(legal_ops[$urandom_range(0, 3)], 8'($urandom), 8'($urandom),
                   1'($urandom), int'($urandom_range(0, 2)));
        end

        run_op(3'(add_op), 8'h40, 8'h40, 1'b0, 0);
        A     = 8'hFF;
        B     = 8'hFF;
        op    = 3'(mul_op);
        start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_result = '0;
        check_val("midreset_done", 32'(done), 32'd0);
        check_val("midreset_result", 32'(result), 32'd0);
        check_val("midreset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < MUL_LAT + 2; c++) begin
            @(negedge clk);
            check_val("midreset_no_done", 32'(done), 32'd0);
            check_val("midreset_result_held", 32'(result), 32'd0);
        end
        run_op(3'(mul_op), 8'h0D, 8'h0B, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
